mac_random_backoff: RTL and testbench

MAC_RANDOM_BACKOFF -- requirements
Module: mac_random_backoff

---
 rtl/mac_random_backoff.sv | 177 +++++++++++++++++
 tb/tb_mac_random_backoff.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mac_random_backoff.sv
// Slotted random-backoff MAC: a Galois-LFSR draw sets the backoff, and the block then holds the transmit gate for TX_SLOTS slots.
// Build option MAC_BEB_EN: binary exponential backoff driven by acks, with a WAIT_ACK timeout.
`timescale 1ns/1ps
module mac_random_backoff #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          CW_MIN      = 2,
  parameter int          CW_MAX      = 5,
  parameter int          TX_SLOTS    = 1,
  parameter int          ACK_TIMEOUT = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trigger_signal,
  input  logic        ack_signal,
  output logic        mac_control_signal,
  output logic [7:0]  backoff_count,
  output logic [1:0]  mac_state,
  output logic [15:0] tx_count
);

  typedef enum logic [1:0] {DRAW = 2'd0, BACKOFF = 2'd1, TRANSMIT = 2'd2, WAIT_ACK = 2'd3} state_t;

  localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [3:0]  W_MIN   = 4'(CW_MIN);
  localparam logic [3:0]  W_MAX   = 4'(CW_MAX);
  localparam logic [7:0]  TX_LOAD = 8'(TX_SLOTS);

  // Taps 0xB400 implement x^16+x^14+x^13+x^11+1 in right-shift Galois form
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [7:0] win_mask(input logic [3:0] w_exp);
    return 8'((9'd1 << w_exp) - 9'd1);
  endfunction

  state_t      state, state_n;
  logic [15:0] lfsr, lfsr_nx;
  logic [7:0]  tx_slot_cnt;
  logic [3:0]  w;
  logic        pending;
  logic        trig_p0, trig_p1, trig_p2;
  logic        ack_p0, ack_p1;
  logic        slot, slot_bo;
  logic        enter_tx, dec_bo, tx_dec, tx_done;
`ifdef MAC_BEB_EN
  logic [31:0] wait_cnt;
  logic        ack_hit, timeout;
`else
  logic        unused_ack;
  assign w          = W_MAX;
  assign unused_ack = ack_p1;
`endif

  assign lfsr_nx   = lfsr_step(lfsr);
  assign slot      = trig_p2 & ~trig_p1;
  assign slot_bo   = slot | pending;
  assign mac_state = state;

  always_comb begin
    state_n  = state;
    enter_tx = 1'b0;
    dec_bo   = 1'b0;
    tx_dec   = 1'b0;
    tx_done  = 1'b0;
`ifdef MAC_BEB_EN
    ack_hit  = 1'b0;
    timeout  = 1'b0;
`endif
    case (state)
      DRAW: state_n = BACKOFF;
      BACKOFF: begin
        if (slot_bo) begin
          if (backoff_count == 8'd0) begin
            state_n  = TRANSMIT;
            enter_tx = 1'b1;
          end else begin
            dec_bo = 1'b1;
          end
        end
      end
      TRANSMIT: begin
        if (slot) begin
          if (tx_slot_cnt <= 8'd1) begin
            tx_done = 1'b1;
`ifdef MAC_BEB_EN
            state_n = WAIT_ACK;
`else
            state_n = DRAW;
`endif
          end else begin
            tx_dec = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
`ifdef MAC_BEB_EN
        // Ack wins over a simultaneous timeout
        if (ack_p1) begin
          ack_hit = 1'b1;
          state_n = DRAW;
        end else if (wait_cnt >= 32'(ACK_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_n = DRAW;
        end
`else
        state_n = DRAW;
`endif
      end
      default: state_n = DRAW;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= DRAW;
      lfsr               <= SEED;
      backoff_count      <= 8'd0;
      tx_count           <= 16'd0;
      tx_slot_cnt        <= 8'd0;
      pending            <= 1'b0;
      trig_p0            <= 1'b0;
      trig_p1            <= 1'b0;
      trig_p2            <= 1'b0;
      ack_p0             <= 1'b0;
      ack_p1             <= 1'b0;
      mac_control_signal <= 1'b0;
    end else begin
      // Stage p0/p1 synchronize; p2 delays for falling-edge detect
      trig_p0            <= trigger_signal;
      trig_p1            <= trig_p0;
      trig_p2            <= trig_p1;
      ack_p0             <= ack_signal;
      ack_p1             <= ack_p0;
      lfsr               <= lfsr_nx;
      state              <= state_n;
      mac_control_signal <= (state_n == TRANSMIT);

      if (state == DRAW)
        backoff_count <= lfsr_nx[7:0] & win_mask(w);
      else if (dec_bo)
        backoff_count <= backoff_count - 8'd1;

      if (enter_tx)
        tx_slot_cnt <= TX_LOAD;
      else if (tx_dec)
        tx_slot_cnt <= tx_slot_cnt - 8'd1;
      else if (tx_done)
        tx_slot_cnt <= 8'd0;

      if (tx_done && tx_count != 16'hFFFF)
        tx_count <= tx_count + 16'd1;

      // Boundaries seen while not counting are credited on entry to BACKOFF
      if (state == BACKOFF)
        pending <= 1'b0;
      else if (slot && state != TRANSMIT)
        pending <= 1'b1;
    end
  end

`ifdef MAC_BEB_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w        <= W_MIN;
      wait_cnt <= 32'd0;
    end else begin
      wait_cnt <= (state == WAIT_ACK && state_n == WAIT_ACK) ? wait_cnt + 32'd1 : 32'd0;
      if (ack_hit)
        w <= W_MIN;
      else if (timeout)
        w <= (w >= W_MAX) ? W_MAX : w + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_random_backoff.sv
// Directed bench for mac_random_backoff: several parameterised instances share one clock and one trigger line.
`timescale 1ns/1ps
module tb_mac_random_backoff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic trig = 1'b0, ack = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0;
  logic ctrl_a, ctrl_b, ctrl_c, ctrl_d;
  logic [7:0]  bo_a, bo_b, bo_c, bo_d;
  logic [1:0]  st_a, st_b, st_c, st_d;
  logic [15:0] txc_a, txc_b, txc_c, txc_d;

  mac_random_backoff dut_a (.clock(clk), .reset(rst_a), .trigger_signal(trig), .ack_signal(1'b0),
    .mac_control_signal(ctrl_a), .backoff_count(bo_a), .mac_state(st_a), .tx_count(txc_a));
  mac_random_backoff #(.CW_MIN(0), .CW_MAX(0)) dut_b (.clock(clk), .reset(rst_b), .trigger_signal(trig),
    .ack_signal(1'b0), .mac_control_signal(ctrl_b), .backoff_count(bo_b), .mac_state(st_b), .tx_count(txc_b));
  mac_random_backoff #(.LFSR_SEED(16'h0000)) dut_c (.clock(clk), .reset(rst_c), .trigger_signal(1'b0),
    .ack_signal(1'b0), .mac_control_signal(ctrl_c), .backoff_count(bo_c), .mac_state(st_c), .tx_count(txc_c));
  mac_random_backoff #(.CW_MIN(1), .CW_MAX(3)) dut_d (.clock(clk), .reset(rst_d), .trigger_signal(trig),
    .ack_signal(ack), .mac_control_signal(ctrl_d), .backoff_count(bo_d), .mac_state(st_d), .tx_count(txc_d));

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'b1011_0100_0000_0000;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    trig = 1'b1;
    clocks(hi);
    trig = 1'b0;
    clocks(lo);
  endtask

  typedef struct {
    logic        exp_ctrl_hi;
    logic [1:0]  exp_state;
    logic [15:0] exp_tx;
  } vec_t;
  vec_t tbl[5];

  logic [15:0] m;
  logic [7:0]  exp_draw;
  int zeros, diffs, n;

  initial begin
    tbl[0] = '{1'b0, 2'd2, 16'd0};
    tbl[1] = '{1'b1, 2'd1, 16'd1};
    tbl[2] = '{1'b0, 2'd2, 16'd1};
    tbl[3] = '{1'b1, 2'd1, 16'd2};
    tbl[4] = '{1'b0, 2'd2, 16'd2};
    clocks(3);

`ifndef MAC_BEB_EN
    // Default instance: reset values and the first draw
    check("a_rst_state", st_a, 0);
    check("a_rst_backoff", bo_a, 0);
    check("a_rst_tx", txc_a, 0);
    check("a_rst_ctrl", ctrl_a, 0);
    check("a_rst_lfsr", dut_a.lfsr, 32'hACE1);
    exp_draw = 8'(ref_step(16'hACE1)) & 8'h1F;
    rst_a = 1'b1;
    clocks(1);
    check("a_first_state", st_a, 1);
    check("a_first_draw", bo_a, exp_draw);
    for (int i = 0; i < int'(exp_draw); i++) pulse(4, 6);
    check("a_bo_drained", bo_a, 0);
    check("a_bo_state", st_a, 1);
    check("a_bo_ctrl", ctrl_a, 0);
    pulse(4, 6);
    check("a_tx_state", st_a, 2);
    check("a_tx_ctrl", ctrl_a, 1);
    trig = 1'b1;
    clocks(2);
    check("a_tx_slot_ctrl", ctrl_a, 1);
    clocks(2);
    trig = 1'b0;
    clocks(6);
    check("a_exit_tx_count", txc_a, 1);
    check("a_exit_ctrl", ctrl_a, 0);
    check("a_exit_state", st_a, 1);
    rst_a = 1'b0;

    // Zero-width window: every slot boundary alternates between backoff and transmit
    rst_b = 1'b1;
    clocks(2);
    foreach (tbl[i]) begin
      trig = 1'b1;
      clocks(10);
      check($sformatf("b_ctrl_slot%0d", i + 1), ctrl_b, tbl[i].exp_ctrl_hi);
      clocks(10);
      trig = 1'b0;
      clocks(40);
      check($sformatf("b_state_slot%0d", i + 1), st_b, tbl[i].exp_state);
      check($sformatf("b_tx_slot%0d", i + 1), txc_b, tbl[i].exp_tx);
    end

    // Asynchronous reset while transmitting
    check("b_pre_rst_ctrl", ctrl_b, 1);
    #2 rst_b = 1'b0;
    #1 check("b_async_ctrl", ctrl_b, 0);
    check("b_async_state", st_b, 0);
    check("b_async_tx", txc_b, 0);
    clocks(1);
    rst_b = 1'b1;
    clocks(1);
    check("b_release_state", st_b, 1);
    check("b_release_tx", txc_b, 0);
    rst_b = 1'b0;
`endif

    // Zero seed is replaced; the sequence is checked against a model over a full period
    check("c_rst_lfsr", dut_c.lfsr, 1);
    rst_c = 1'b1;
    m = 16'h0001;
    zeros = 0;
    diffs = 0;
    for (int i = 0; i < 70000; i++) begin
      clocks(1);
      m = ref_step(m);
      if (dut_c.lfsr == 16'h0000) zeros++;
      if (dut_c.lfsr !== m) diffs++;
    end
    check("c_lfsr_zero_hits", zeros, 0);
    check("c_lfsr_model_diffs", diffs, 0);
    rst_c = 1'b0;

`ifdef MAC_BEB_EN
    rst_d = 1'b1;
    clocks(1);
    check("d_w_start", dut_d.w, 1);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (st_d != 2'd2 && n < 20) begin
        pulse(4, 6);
        n++;
      end
      check($sformatf("d_reach_tx%0d", k), st_d, 2);
      trig = 1'b1;
      clocks(4);
      trig = 1'b0;
      n = 0;
      while (st_d != 2'd3 && n < 10) begin
        clocks(1);
        n++;
      end
      check($sformatf("d_wait_ack%0d", k), st_d, 3);
      if (k < 4) begin
        n = 1;
        while (st_d == 2'd3 && n < 2000) begin
          clocks(1);
          if (st_d == 2'd3) n++;
        end
        check($sformatf("d_wait_len%0d", k), n, 1000);
        check($sformatf("d_w_after%0d", k), dut_d.w, (k == 0) ? 2 : 3);
      end else begin
        clocks(9);
        ack = 1'b1;
        n = 0;
        while (st_d != 2'd0 && n < 4) begin
          clocks(1);
          n++;
        end
        ack = 1'b0;
        check("d_ack_draw", st_d, 0);
        check("d_ack_w", dut_d.w, 1);
      end
      clocks(3);
    end
    rst_d = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
